// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Holds the LSU state encoding, the access-size codes and a misalignment
// helper that the alignment logic uses.
package definitions_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  // A half needs an even address; a word (and the reserved code, which
  // behaves as a word) needs both low address bits clear.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_BYTE: mis = 1'b0;
      MEM_HALF: mis = addr_lo[0];
      default:  mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the LSU and the memory responder.
// req/we/addr/be/wdata travel from the LSU (master) to memory (slave);
// gnt/rvalid/rdata travel back. These map onto dmem_*_o / dmem_*_i.
interface mem_lsu_if #(
  parameter int XLEN = 32
);

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_lsu_align.sv
// Pure combinational byte-lane logic for the LSU.
// Store side works on the live pipeline inputs (byte enables, lane
// replication, misalignment); load side works on the latched access and
// the returned memory word (lane extract plus sign/zero extension).
// Optional feature macro: LSU_MISALIGN_TRAP_EN adds the o_misalign output.
module mem_align
  import definitions_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        o_misalign,
`endif
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_sign,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [1:0]  w_ld_lane;
  logic [31:0] w_ld_shifted;

  // Byte enables and lane-replicated store data; a half ignores addr[0]
  // and a word always covers all four lanes.
  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_wdata;
    case (i_st_size)
      MEM_BYTE: begin
        o_st_be    = 4'b0001 << i_st_addr_lo;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      MEM_HALF: begin
        o_st_be    = 4'b0011 << {i_st_addr_lo[1], 1'b0};
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign o_misalign = lsu_misaligned(i_st_size, i_st_addr_lo);
`endif

  // Pick the starting lane of the loaded value, matching the store lanes.
  always_comb begin
    w_ld_lane = 2'b00;
    case (i_ld_size)
      MEM_BYTE: w_ld_lane = i_ld_addr_lo;
      MEM_HALF: w_ld_lane = {i_ld_addr_lo[1], 1'b0};
      default:  w_ld_lane = 2'b00;
    endcase
  end

  assign w_ld_shifted = i_ld_rdata >> {w_ld_lane, 3'b000};

  // Mask to the access size and extend to 32 bits.
  always_comb begin
    o_ld_data = w_ld_shifted;
    case (i_ld_size)
      MEM_BYTE: o_ld_data = {{24{i_ld_sign & w_ld_shifted[7]}},  w_ld_shifted[7:0]};
      MEM_HALF: o_ld_data = {{16{i_ld_sign & w_ld_shifted[15]}}, w_ld_shifted[15:0]};
      default:  o_ld_data = w_ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit of the RV32I pipeline.
// Latches a load/store from the MEM stage, runs it over the req/gnt/rvalid
// bus and stalls the pipeline until the access completes. Store beats load
// when both are requested together.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned accesses skip
// the bus and finish with misalign_o set; otherwise low address bits are
// ignored and misalign_o is tied low.
module mem_lsu
  import definitions_pkg::*;
#(
  parameter int XLEN = 32
)
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mem_write_mem_i,
  input  logic            mem_read_mem_i,
  input  logic [1:0]      data_memory_size_mem_i,
  input  logic            data_memory_sign_mem_i,
  input  logic [XLEN-1:0] addr_mem_i,
  input  logic [XLEN-1:0] wdata_mem_i,
  mem_lsu_if.master       dmem,
  output logic            stall_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            rdata_valid_o,
  output logic            misalign_o
);

  lsu_state_t      r_state;
  logic [XLEN-1:0] r_addr;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;
  logic [1:0]      r_size;
  logic            r_sign;
  logic            r_we;
  logic            r_req;
  logic [XLEN-1:0] r_rdata;
  logic            r_rdata_valid;
`ifdef LSU_MISALIGN_TRAP_EN
  logic            r_misalign;
  logic            w_misalign;
`endif

  logic            w_access;
  logic [3:0]      w_be;
  logic [31:0]     w_st_wdata;
  logic [31:0]     w_ld_data;

  assign w_access = mem_write_mem_i | mem_read_mem_i;

  mem_align u_align (
    .i_st_size    (data_memory_size_mem_i),
    .i_st_addr_lo (addr_mem_i[1:0]),
    .i_st_wdata   (wdata_mem_i),
    .o_st_be      (w_be),
    .o_st_wdata   (w_st_wdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .o_misalign   (w_misalign),
`endif
    .i_ld_size    (r_size),
    .i_ld_sign    (r_sign),
    .i_ld_addr_lo (r_addr[1:0]),
    .i_ld_rdata   (dmem.rdata),
    .o_ld_data    (w_ld_data)
  );

  // Access FSM: latch in IDLE, hold the request until gnt, wait for
  // rvalid on loads, then release the pipeline for one DONE cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_be          <= '0;
      r_wdata       <= '0;
      r_size        <= '0;
      r_sign        <= 1'b0;
      r_we          <= 1'b0;
      r_req         <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_addr  <= addr_mem_i;
            r_be    <= w_be;
            r_wdata <= w_st_wdata;
            r_size  <= data_memory_size_mem_i;
            r_sign  <= data_memory_sign_mem_i;
            r_we    <= mem_write_mem_i;
`ifdef LSU_MISALIGN_TRAP_EN
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_req   <= 1'b1;
              r_state <= REQ;
            end
`else
            r_req   <= 1'b1;
            r_state <= REQ;
`endif
          end
        end
        REQ: begin
          if (dmem.gnt) begin
            r_req   <= 1'b0;
            r_state <= r_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (dmem.rvalid) begin
            r_rdata       <= w_ld_data;
            r_rdata_valid <= 1'b1;
            r_state       <= DONE;
          end
        end
        DONE: begin
          r_rdata_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          r_misalign    <= 1'b0;
`endif
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Freeze the pipeline from the cycle an access shows up until DONE.
  always_comb begin
    stall_o = ((r_state == IDLE) && w_access) || (r_state == REQ) || (r_state == WAIT);
  end

  assign dmem.req      = r_req;
  assign dmem.we       = r_we;
  assign dmem.addr     = {r_addr[XLEN-1:2], 2'b00};
  assign dmem.be       = r_be;
  assign dmem.wdata    = r_wdata;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rdata_valid;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o    = r_misalign;
`else
  assign misalign_o    = 1'b0;
`endif

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit of the 5-stage RV32I pipeline. It consumes the memory-stage control bundle (`mem_write`, `result_src`, `data_memory_size`, `data_memory_sign`) plus the ALU address and store data. It drives a req/gnt/rvalid data-memory bus with byte-lane alignment, and returns sign- or zero-extended load data. It holds the pipeline stalled until the access completes.

## Interface
- `XLEN`, default 32: data/address width; only 32 is supported.
- `clk_i` input 1: clock, rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `mem_write_mem_i` input 1: store request this cycle.
- `mem_read_mem_i` input 1: load request this cycle; it is `result_src == 2'b01`, decoded upstream.
- `data_memory_size_mem_i` input 2: `00` byte, `01` half, `10` word, `11` reserved (treated as word).
- `data_memory_sign_mem_i` input 1: 1 = sign-extend load, 0 = zero-extend.
- `addr_mem_i` input XLEN: byte address.
- `wdata_mem_i` input XLEN: store data, LSB-justified.
- `dmem_req_o` output 1: bus request.
- `dmem_we_o` output 1: 1 = write.
- `dmem_addr_o` output XLEN: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_be_o` output 4: byte enables.
- `dmem_wdata_o` output XLEN: lane-replicated store data.
- `dmem_gnt_i` input 1: request accepted.
- `dmem_rvalid_i` input 1: read data valid.
- `dmem_rdata_i` input XLEN: read word.
- `stall_o` output 1: freeze IF..MEM pipeline registers.
- `rdata_o` output XLEN: extended load result.
- `rdata_valid_o` output 1: `rdata_o` valid this cycle.
- `misalign_o` output 1: misaligned-access flag; constant 0 when the feature is compiled out.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If load or store is asserted, latch addr, be, wdata, size, sign and we into registers.
  - Aligned access → REQ. Misaligned access with the feature enabled → DONE with error flag.
  - If both load and store are asserted, the store wins.
- **REQ**
  - `dmem_req_o` = 1. Bus outputs are driven from registers and stay stable until gnt.
  - On gnt: store → DONE; load → WAIT.
- **WAIT**: on rvalid, capture and extend `dmem_rdata_i` into `rdata_q`, → DONE. rvalid is ignored in every other state.
- **DONE**
  - `stall_o` = 0; `rdata_valid_o` = 1 for loads; `misalign_o` = error flag.
  - Always → IDLE. The pipeline advances on this edge.
- `stall_o` = (IDLE && access present) || REQ || WAIT. This output is combinational.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
- Store data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word as is.
- Load extract: shift `dmem_rdata_i` right by `addr[1:0]*8`, mask to size, then sign- or zero-extend per `sign`.
- Misaligned means half with `addr[0]=1`, or word with `addr[1:0]!=0`.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE.
  - All outputs 0: `dmem_req_o`, `dmem_we_o`, `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o`, `rdata_o`, `rdata_valid_o`, `misalign_o`. `stall_o` follows its combinational equation.
  - A pending rvalid after reset is dropped.
- Store, gnt in the first REQ cycle: 2 stall cycles (IDLE, REQ), DONE on the 3rd cycle.
- Load, gnt in the first REQ cycle and rvalid the next cycle: 3 stall cycles, `rdata_valid_o` on the 4th cycle.
- gnt wait states add one stall cycle each. `dmem_req_o` stays high and its payload does not change.
- Responder guarantee: rvalid arrives no earlier than one cycle after gnt, and at most one transaction is outstanding.
- `rdata_o` holds its value until the next load completes.
- Back-to-back accesses: the next access is sampled in IDLE on the cycle after DONE. There are no dead cycles beyond that.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access issues no bus request.
  - IDLE → DONE, 1 stall cycle; `misalign_o` = 1 in DONE; `rdata_valid_o` = 0.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Low address bits are silently ignored: half uses `addr[1]`, word forces lane 0.
  - `misalign_o` is tied to 0 and the error-flag register is not built.

## Structure
- `definitions_pkg` holds:
  - `lsu_state_t` enum (IDLE, REQ, WAIT, DONE).
  - Size constants `MEM_BYTE=2'b00`, `MEM_HALF=2'b01`, `MEM_WORD=2'b10`.
- One combinational sub-module, `mem_align`, computes be, store replication, load extract/extend and misalign detection.
- `mem_lsu` holds the FSM and the registers.

## Test plan
- SB `addr=0x1003`, `wdata=0x000000A5`, gnt immediate → `dmem_be_o=4'b1000`, `dmem_wdata_o=0xA5A5A5A5`, `dmem_addr_o=0x1000`, `stall_o` high 2 cycles.
- LB sign=1 `addr=0x2001`, `rdata=0x0000_8000`, gnt and rvalid one cycle apart → `rdata_o=0xFFFFFF80`; LBU (sign=0) → `0x00000080`.
- LH `addr=0x2002`, `rdata=0xBEEF1234`, gnt held off 3 cycles → request stable throughout, `rdata_o=0xFFFFBEEF`, 6 stall cycles total.
- LW `addr=0x3002` with the macro defined → no `dmem_req_o`, `misalign_o=1` for 1 cycle. Without the macro → word read at `0x3000`, `misalign_o=0`.
- Assert `rst_ni` low while in WAIT → `dmem_req_o`, `stall_o` and `rdata_valid_o` fall to 0 immediately; a later rvalid produces no `rdata_valid_o`.
